// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: read-mode selectors and the count width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // count spans 0..DEPTH inclusive, so it needs one bit beyond the address
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, combinational read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered flags, exact fill count, error pulses and
// optional first-word-fall-through read mode.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rvalid,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic [count_width(ADDR_WIDTH)-1:0]   count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int CNT_W = count_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  rd_acc, wr_acc;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(wdata),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        // a read in the same cycle frees the slot, so a full FIFO can still accept
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        ovf_d    = wr_en & ~wr_acc;
        unf_d    = rd_en & ~rd_acc;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (FWFT == FIFO_FWFT) begin
            // look ahead to the head slot after this edge; bypass when it is being written now
            ram_raddr = rd_ptr_d[ADDR_WIDTH-1:0];
            rvalid_d  = ~empty_d;
            if (wr_acc && (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0])) begin
                rdata_d = wdata;
            end else if (!empty_d) begin
                rdata_d = ram_rdata;
            end
        end else begin
            ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
            rvalid_d  = rd_acc;
            if (rd_acc) begin
                rdata_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a standard-read and an FWFT instance driven in lockstep
// against a queue-based reference model.
module tb_fifo_sync_flags;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] rdata_s, rdata_f;
    logic          rvalid_s, rvalid_f, full_s, full_f, empty_s, empty_f;
    logic          af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [AW:0]   count_s, count_f;

    fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_STD)) dut_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_s), .rvalid(rvalid_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    fifo_sync_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_FWFT)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_f), .rvalid(rvalid_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: contents as a queue, outputs derived from its size
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata0 = '0, m_rdata1 = '0;
    logic          m_rv0 = 1'b0, m_rv1 = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    task automatic model_reset();
        q.delete();
        m_rdata0 = '0;
        m_rdata1 = '0;
        m_rv0    = 1'b0;
        m_rv1    = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r);
        bit ra, wa;
        ra = r && (q.size() > 0);
        wa = w && ((q.size() < DEPTH) || ra);
        m_rv0 = ra;
        if (ra) begin
            m_rdata0 = q[0];
            void'(q.pop_front());
        end
        if (wa) q.push_back(d);
        m_ovf = w && !wa;
        m_unf = r && !ra;
        m_rv1 = (q.size() > 0);
        if (m_rv1) m_rdata1 = q[0];
    endtask

    task automatic check_all();
        chk("count",        32'(count_s),  32'(q.size()));
        chk("count_fwft",   32'(count_f),  32'(q.size()));
        chk("full",         32'(full_s),   32'(q.size() == DEPTH));
        chk("empty",        32'(empty_s),  32'(q.size() == 0));
        chk("empty_fwft",   32'(empty_f),  32'(q.size() == 0));
        chk("almost_full",  32'(af_s),     32'(q.size() >= DEPTH - 2));
        chk("almost_empty", 32'(ae_s),     32'(q.size() <= 2));
        chk("overflow",     32'(ovf_s),    32'(m_ovf));
        chk("underflow",    32'(unf_s),    32'(m_unf));
        chk("rvalid",       32'(rvalid_s), 32'(m_rv0));
        chk("rdata",        32'(rdata_s),  32'(m_rdata0));
        chk("rvalid_fwft",  32'(rvalid_f), 32'(m_rv1));
        if (m_rv1) chk("rdata_fwft", 32'(rdata_f), 32'(m_rdata1));
    endtask

    // called at a falling edge; leaves the bench at the next falling edge
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        model_edge(w, d, r);
        @(negedge clk);
        check_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          rd;
        logic [AW:0]   cnt;
        logic          emp;
        logic          unf;
        logic          rv;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 8'h11};
        tbl[3] = '{1'b1, 8'h22, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[4] = '{1'b1, 8'h33, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'h22};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h33};

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("reset_ae", 32'(ae_s), 32'd1);
        chk("reset_rdata_fwft", 32'(rdata_f), 32'd0);

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rd);
            chk("tbl_count",     32'(count_s),  32'(tbl[i].cnt));
            chk("tbl_empty",     32'(empty_s),  32'(tbl[i].emp));
            chk("tbl_underflow", 32'(unf_s),    32'(tbl[i].unf));
            chk("tbl_rvalid",    32'(rvalid_s), 32'(tbl[i].rv));
            chk("tbl_rdata",     32'(rdata_s),  32'(tbl[i].rdata));
        end

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i + 1), 1'b0);
            chk("af_threshold", 32'(af_s), 32'(i + 1 >= 14));
        end
        chk("full_after_16", 32'(full_s), 32'd1);
        step(1'b1, 8'h77, 1'b0);
        chk("overflow_pulse", 32'(ovf_s), 32'd1);
        chk("count_stays_16", 32'(count_s), 32'd16);
        step(1'b0, 8'h00, 1'b0);
        chk("overflow_one_cycle", 32'(ovf_s), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_order", 32'(rdata_s), 32'(i + 1));
        end
        chk("empty_after_drain", 32'(empty_s), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("underflow_pulse", 32'(unf_s), 32'd1);
        chk("rdata_holds", 32'(rdata_s), 32'h10);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 1), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        chk("full_rw_old_word", 32'(rdata_s), 32'h01);
        chk("full_rw_stays_full", 32'(full_s), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("full_rw_order", 32'(rdata_s), (i == DEPTH - 1) ? 32'hAA : 32'(i + 2));
        end

        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1);
            chk("stream_count", 32'(count_s), 32'd3);
            chk("stream_data", 32'(rdata_s), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'h5A, 1'b0);
        chk("fwft_first_rvalid", 32'(rvalid_f), 32'd1);
        chk("fwft_first_rdata", 32'(rdata_f), 32'h5A);
        step(1'b1, 8'h5B, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_next", 32'(rdata_f), 32'h5B);
        chk("fwft_pop_rvalid", 32'(rvalid_f), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_drained", 32'(rvalid_f), 32'd0);

        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        wr_en = 1'b1;
        wdata = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_s), 32'd0);
        chk("arst_empty", 32'(empty_s), 32'd1);
        chk("arst_ae", 32'(ae_s), 32'd1);
        chk("arst_af", 32'(af_s), 32'd0);
        chk("arst_rdata", 32'(rdata_s), 32'd0);
        chk("arst_rvalid_fwft", 32'(rvalid_f), 32'd0);
        chk("arst_rdata_fwft", 32'(rdata_f), 32'd0);
        chk("arst_count_fwft", 32'(count_f), 32'd0);
        wr_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        step(1'b1, 8'hC3, 1'b0);
        chk("post_rst_fwft", 32'(rdata_f), 32'hC3);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_read", 32'(rdata_s), 32'hC3);

        for (int ph = 0; ph < 3; ph++) begin
            int wp;
            wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            for (int i = 0; i < 1000; i++) begin
                step(1'($urandom_range(0, 99) < wp), 8'($urandom),
                     1'($urandom_range(0, 99) < 100 - wp + 5));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO: storage, pointers and status flags in one block, replacing the bare storage-plus-external-pointer arrangement used so far. Adds full/empty/almost flags, an exact fill count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Sits between any producer and consumer sharing `clk`.

## Interface
- `DATA_WIDTH`, 8, word width in bits
- `ADDR_WIDTH`, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (≥ 2)
- `AFULL_TH`, DEPTH-2, `almost_full` asserted when count ≥ AFULL_TH
- `AEMPTY_TH`, 2, `almost_empty` asserted when count ≤ AEMPTY_TH
- `FWFT`, 0, 0 = standard registered read, 1 = first-word-fall-through
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `wr_en`  in  1  write request
- `wdata`  in  DATA_WIDTH  write data
- `rd_en`  in  1  read request (FWFT: acknowledge of current `rdata`)
- `rdata`  out  DATA_WIDTH  read data
- `rvalid`  out  1  `rdata` valid
- `full`, `empty`  out  1  status
- `almost_full`, `almost_empty`  out  1  threshold status
- `count`  out  ADDR_WIDTH+1  words held, 0..DEPTH
- `overflow`, `underflow`  out  1  one-cycle error pulses

## Operation
- Pointers ADDR_WIDTH+1 bits; MSB is wrap bit. empty: pointers equal. full: addresses equal, wrap bits differ. Wrap from DEPTH-1 to 0 is natural modulo.
- Write accepted = `wr_en & (!full | rd_accepted)`; rejected write → `overflow` = 1 next cycle, state unchanged.
- Read accepted = `rd_en & !empty`; rejected read → `underflow` = 1 next cycle. Write into empty FIFO does not enable a same-cycle read.
- Simultaneous accepted read and write: count unchanged. On full, the read returns the old word before the slot is overwritten.
- `count` +1 on write only, −1 on read only. Never exceeds DEPTH, never goes below 0.
- FWFT=0: `rdata` registered, updates only on accepted read, otherwise holds. `rvalid` pulses one cycle per accepted read.
- FWFT=1: head word presented on `rdata` with `rvalid` = !empty. `rd_en` pops. Capacity and `count` include the presented word. Write into empty FIFO is visible on the next cycle.
- Thresholds are compared against registered `count`.
- Reset (asynchronous, any time, including mid-burst): pointers = 0, `count` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `rvalid` = 0, `rdata` = 0, `overflow` = 0, `underflow` = 0. Storage contents are not reset.

## Timing
- All outputs registered. Flags and `count` reflect the edge at which an access is accepted and are visible the following cycle.
- FWFT=0: read latency 1 cycle from `rd_en` edge to `rdata`/`rvalid`.
- FWFT=1: write-to-`rvalid` latency 1 cycle when empty. After a pop, the next word is on `rdata` in the following cycle with no bubble.
- Sustained one read and one write per cycle at any fill level, 1..DEPTH-1, and at full per the rule above.

## Structure
- Package `fifo_pkg`: FWFT mode constants (`FIFO_STD`, `FIFO_FWFT`) and a function for the count width.
- Sub-module `fifo_ram`: dual-port array with synchronous write and unregistered read address path. Output register, pointers and flags stay in `fifo_sync_flags`.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16, FWFT=0) → `full` after 16th write, `count`=16, `almost_full` from count 14. 17th write → `overflow` pulse, `count` stays 16.
- Read 16 from full → data 0x01..0x10 in order, 1-cycle latency. `empty` after last read. Extra `rd_en` → `underflow` pulse, `rdata` holds 0x10.
- At full, simultaneous read and write of 0xAA → read returns oldest word, `full` stays 1, 0xAA emerges 16 reads later.
- 40 cycles of continuous read and write at count 3 → `count` constant 3, pointers wrap twice, order preserved.
- FWFT=1: write 0x5A into empty → `rvalid` = 1 and `rdata` = 0x5A the next cycle without `rd_en`. Pop with a queued 0x5B → 0x5B presented the next cycle.
- Assert `rst_n` low mid-burst at count 7 → all outputs take reset values immediately (async). After release, first write/read returns the new data only.
